// File: rtl/hiscore_upload.sv
// hiscore_upload
//   Upload-side responder for the hiscore save path. Captures the hiscore
//   config table streamed on ioctl index 3. It then answers HPS upload byte
//   requests by mapping the linear save-file offset onto the table's scattered
//   game-RAM regions. The byte is read from game RAM and returned under an
//   ioctl_wait handshake.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ioctl_download    HPS download active (config table on index 3)
//   ioctl_upload      HPS upload active
//   ioctl_wr          download byte strobe
//   ioctl_rd          upload byte request strobe (one cycle)
//   ioctl_addr        download offset / upload offset
//   ioctl_dout        download data
//   ioctl_index       ioctl file index
//   ioctl_din         upload data returned to HPS
//   ioctl_wait        high while a request is outstanding
//   ram_address       game-RAM read address
//   ram_read          one-cycle game-RAM read strobe
//   ram_data_in       game-RAM read data, RAM_LATENCY cycles after ram_read
//   upload_size       total save-file bytes (saturating sum of entry lengths)
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for an upload byte request
//   SEEK    | walking table entries until one covers the requested offset
//   ISSUE   | ram_read pulse on the resolved game-RAM address
//   WAIT    | counting RAM_LATENCY, then capturing ram_data_in
//   DONE    | response valid on ioctl_din; drop ioctl_wait

module hiscore_upload #(
    parameter int RAM_AW      = 10,
    parameter int ENTRY_AW    = 4,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic              ioctl_wr,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [RAM_AW-1:0] ram_address,
    output logic              ram_read,
    input  logic [7:0]        ram_data_in,
    output logic [15:0]       upload_size
);

    localparam int ENTRIES = 1 << ENTRY_AW;
    localparam int CW      = ENTRY_AW + 1;   // counts 0..ENTRIES
    localparam int LW      = 2;              // RAM_LATENCY is 1..3

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEEK  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Config table capture
    // ------------------------------------------------------------------
    logic [23:0]         base_mem [ENTRIES];
    logic [7:0]          len_mem  [ENTRIES];
    logic [CW-1:0]       entry_count;
    logic                dl_q;
    logic                cfg_sel;
    logic                cfg_wr;
    logic                dl_start;
    logic                rec_in_range;
    logic [ENTRY_AW-1:0] rec_n;
    logic [2:0]          rec_byte;
    logic [16:0]         size_sum;

    assign rec_n        = ioctl_addr[ENTRY_AW+2:3];
    assign rec_byte     = ioctl_addr[2:0];
    assign rec_in_range = (ioctl_addr[24:ENTRY_AW+3] == '0);
    assign cfg_sel      = (ioctl_index == 8'd3);
    assign cfg_wr       = ioctl_download & ioctl_wr & cfg_sel & rec_in_range;
    assign dl_start     = ioctl_download & ~dl_q & cfg_sel;
    assign size_sum     = {1'b0, upload_size} + {9'd0, ioctl_dout};

    // Table storage carries no reset: entries at or above entry_count are
    // never consulted, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            case (rec_byte)
                3'd1:    base_mem[rec_n][23:16] <= ioctl_dout;
                3'd2:    base_mem[rec_n][15:8]  <= ioctl_dout;
                3'd3:    base_mem[rec_n][7:0]   <= ioctl_dout;
                3'd4:    len_mem[rec_n]         <= ioctl_dout;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q        <= 1'b0;
            entry_count <= '0;
            upload_size <= '0;
        end else begin
            dl_q <= ioctl_download;
            if (dl_start) begin
                entry_count <= '0;
                upload_size <= '0;
            end else if (cfg_wr && rec_byte == 3'd4) begin
                // Records arrive in ascending order, so the latest length
                // byte also defines the table size.
                entry_count <= CW'(rec_n) + CW'(1);
                upload_size <= size_sum[16] ? 16'hFFFF : size_sum[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Upload cursor and address resolution
    // ------------------------------------------------------------------
    logic [15:0]   off_q;
    logic [15:0]   cur_start;
    logic [CW-1:0] cur_entry;
    logic [7:0]    cur_len;
    logic [23:0]   cur_base;
    logic [16:0]   cur_end;
    logic [15:0]   rel_off;
    logic [23:0]   ram_addr_full;
    logic          seek_end;
    logic          seek_hit;
    logic          req_accept;
    logic [LW-1:0] lat_cnt;
    logic          unused_addr_hi;

    assign cur_len        = len_mem[cur_entry[ENTRY_AW-1:0]];
    assign cur_base       = base_mem[cur_entry[ENTRY_AW-1:0]];
    assign cur_end        = {1'b0, cur_start} + {9'd0, cur_len};
    assign seek_end       = (cur_entry >= entry_count);
    assign seek_hit       = ({1'b0, off_q} < cur_end);
    assign rel_off        = off_q - cur_start;
    assign ram_addr_full  = cur_base + {8'd0, rel_off};
    assign req_accept     = ioctl_rd & ioctl_upload;
    assign unused_addr_hi = ^ram_addr_full[23:RAM_AW];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A falling ioctl_upload aborts from any busy state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_accept) begin
                    state_d = S_SEEK;
                end
            end
            S_SEEK: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                end else if (seek_end) begin
                    state_d = S_DONE;
                end else if (seek_hit) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = ioctl_upload ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!ioctl_upload) begin
                    state_d = S_IDLE;
                end else if (lat_cnt == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the state register
    // ------------------------------------------------------------------
    always_comb begin
        ioctl_wait = 1'b0;
        ram_read   = 1'b0;
        if (state_q != S_IDLE) begin
            ioctl_wait = 1'b1;
        end
        if (state_q == S_ISSUE) begin
            ram_read = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: cursor, RAM address, latency counter, returned byte
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            off_q       <= '0;
            cur_entry   <= '0;
            cur_start   <= '0;
            ram_address <= '0;
            ioctl_din   <= '0;
            lat_cnt     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_accept) begin
                        off_q <= ioctl_addr[15:0];
                        // The cursor only walks forward; rewind for earlier offsets.
                        if (ioctl_addr[15:0] < cur_start) begin
                            cur_entry <= '0;
                            cur_start <= '0;
                        end
                    end
                end
                S_SEEK: begin
                    if (ioctl_upload) begin
                        if (seek_end) begin
                            ioctl_din <= 8'h00;
                        end else if (seek_hit) begin
                            // Address is registered here so it is stable for
                            // the whole ISSUE cycle in which ram_read is high.
                            ram_address <= ram_addr_full[RAM_AW-1:0];
                        end else begin
                            cur_start <= cur_end[15:0];
                            cur_entry <= cur_entry + CW'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LW'(RAM_LATENCY - 1);
                end
                S_WAIT: begin
                    if (ioctl_upload) begin
                        if (lat_cnt == '0) begin
                            ioctl_din <= ram_data_in;
                        end else begin
                            lat_cnt <= lat_cnt - LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hiscore_upload.sv
module tb_hiscore_upload;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic        ioctl_wr;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [9:0]  ram_address;
    logic        ram_read;
    logic [7:0]  ram_data_in;
    logic [15:0] upload_size;

    hiscore_upload #(.RAM_AW(10), .ENTRY_AW(4), .RAM_LATENCY(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_wr       (ioctl_wr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .ram_address    (ram_address),
        .ram_read       (ram_read),
        .ram_data_in    (ram_data_in),
        .upload_size    (upload_size)
    );

    always #5 clk = ~clk;

    // Game-RAM model, one cycle latency; junk when not being read so a
    // mistimed capture shows up.
    function automatic logic [7:0] ram_val(input logic [9:0] a);
        return (a[7:0] ^ 8'h5A) + {6'd0, a[9:8]};
    endfunction

    always @(posedge clk) begin
        if (ram_read) ram_data_in <= ram_val(ram_address);
        else          ram_data_in <= 8'hEE;
    end

    typedef struct {
        bit         has_ram;
        logic [9:0] addr;
        logic [7:0] din;
        int         ram_c;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per
    // completed request (ioctl_wait falling).
    int         cyc = 0;
    int         t_rd = 0;
    int         ram_cyc = 0;
    int         ram_n = 0;
    logic [9:0] ram_addr_seen = '0;
    logic       wait_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ram_read) begin
            ram_n++;
            ram_cyc       = cyc - t_rd;
            ram_addr_seen = ram_address;
        end
        if (wait_prev && !ioctl_wait) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_response: din=%0h with no pending expectation", ioctl_din);
            end else begin
                e = exp_q.pop_front();
                check("ram_read_count", ram_n, e.has_ram ? 1 : 0);
                if (e.has_ram) begin
                    check("ram_address", {22'd0, ram_addr_seen}, {22'd0, e.addr});
                    check("ram_read_cycle", ram_cyc, e.ram_c);
                end
                check("ioctl_din", {24'd0, ioctl_din}, {24'd0, e.din});
                check("wait_low_cycle", cyc - t_rd, e.lat);
            end
        end
        if (ioctl_rd && ioctl_upload && !ioctl_wait && !reset) begin
            t_rd  = cyc;
            ram_n = 0;
        end
        wait_prev = ioctl_wait;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input bit has_ram, input logic [9:0] a, input logic [7:0] d,
                        input int rc, input int lat);
        exp_t x;
        x.has_ram = has_ram;
        x.addr    = a;
        x.din     = d;
        x.ram_c   = rc;
        x.lat     = lat;
        exp_q.push_back(x);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 40 && ioctl_wait; n++) begin
            @(posedge clk); #1;
        end
        if (ioctl_wait) check("wait_timeout", 32'd1, 32'd0);
    endtask

    task automatic req(input int off, input bit has_ram, input logic [9:0] a,
                       input logic [7:0] d, input int rc, input int lat);
        push(has_ram, a, d, rc, lat);
        @(posedge clk); #1;
        ioctl_addr = 25'(off);
        ioctl_rd   = 1'b1;
        @(posedge clk); #1;
        ioctl_rd   = 1'b0;
        wait_idle();
        @(posedge clk); #1;
    endtask

    task automatic dl_begin();
        @(posedge clk); #1;
        ioctl_download = 1'b1;
        ioctl_index    = 8'd3;
        @(posedge clk); #1;
    endtask

    task automatic dl_byte(input int a, input logic [7:0] d);
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(posedge clk); #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic dl_record(input int n, input logic [63:0] rec);
        for (int k = 0; k < 8; k++) dl_byte(n * 8 + k, rec[63 - 8 * k -: 8]);
    endtask

    task automatic dl_end();
        ioctl_download = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ioctl_din", {24'd0, ioctl_din}, 32'h0);
        check("rst_ioctl_wait", {31'd0, ioctl_wait}, 32'h0);
        check("rst_ram_address", {22'd0, ram_address}, 32'h0);
        check("rst_ram_read", {31'd0, ram_read}, 32'h0);
        check("rst_upload_size", {16'd0, upload_size}, 32'h0);
        reset = 1'b0;

        // Config: rec0 base 0x00B len 15, rec1 base 0x023 len 4, rec16 dropped.
        dl_begin();
        dl_record(0,  64'h77_00_00_0B_0F_11_22_33);
        dl_record(1,  64'h00_00_00_23_04_55_66_77);
        dl_record(16, 64'h00_00_00_40_09_00_00_00);
        dl_end();
        check("cfg_upload_size", {16'd0, upload_size}, 32'd19);

        ioctl_upload = 1'b1;
        req(0,   1, 10'h00B, ram_val(10'h00B), 2, 5);
        req(14,  1, 10'h019, ram_val(10'h019), 2, 5);
        req(15,  1, 10'h023, ram_val(10'h023), 3, 6);
        req(18,  1, 10'h026, ram_val(10'h026), 2, 5);
        req(19,  0, 10'h000, 8'h00, 0, 4);
        req(300, 0, 10'h000, 8'h00, 0, 3);
        req(16,  1, 10'h024, ram_val(10'h024), 3, 6);
        req(2,   1, 10'h00D, ram_val(10'h00D), 2, 5);

        // rd during ioctl_wait is ignored: only offset 5 is served.
        push(1, 10'h010, ram_val(10'h010), 2, 5);
        @(posedge clk); #1;
        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        @(posedge clk); #1;
        ioctl_rd   = 1'b0;
        @(posedge clk); #1;
        ioctl_addr = 25'd10;
        ioctl_rd   = 1'b1;
        @(posedge clk); #1;
        ioctl_rd   = 1'b0;
        wait_idle();
        @(posedge clk); #1;

        // Abort in WAIT: ioctl_din keeps the previous byte.
        push(1, 10'h00E, ram_val(10'h010), 2, 4);
        @(posedge clk); #1;
        ioctl_addr = 25'd3;
        ioctl_rd   = 1'b1;
        @(posedge clk); #1;
        ioctl_rd   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ioctl_upload = 1'b0;
        @(posedge clk); #1;
        check("abort_wait", {31'd0, ioctl_wait}, 32'h0);
        check("abort_ram_read", {31'd0, ram_read}, 32'h0);
        ioctl_upload = 1'b1;
        @(posedge clk); #1;

        // Reset while in SEEK.
        push(0, 10'h000, 8'h00, 0, 2);
        @(posedge clk); #1;
        ioctl_addr = 25'd18;
        ioctl_rd   = 1'b1;
        @(posedge clk); #1;
        ioctl_rd   = 1'b0;
        reset      = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        check("mid_rst_din", {24'd0, ioctl_din}, 32'h0);
        check("mid_rst_wait", {31'd0, ioctl_wait}, 32'h0);
        check("mid_rst_ram_address", {22'd0, ram_address}, 32'h0);
        check("mid_rst_ram_read", {31'd0, ram_read}, 32'h0);
        check("mid_rst_upload_size", {16'd0, upload_size}, 32'h0);
        req(0, 0, 10'h000, 8'h00, 0, 3);

        // Saturation: 260 length writes of 0xFF exceed 16 bits.
        ioctl_upload = 1'b0;
        dl_begin();
        for (int i = 0; i < 260; i++) dl_byte(4, 8'hFF);
        dl_end();
        check("sat_upload_size", {16'd0, upload_size}, 32'h0000FFFF);

        // Re-download: one record, base 0x012503 truncates to 0x103.
        dl_begin();
        dl_record(0, 64'h00_01_25_03_04_00_00_00);
        dl_end();
        check("redl_upload_size", {16'd0, upload_size}, 32'd4);

        ioctl_upload = 1'b1;
        req(3, 1, 10'h106, ram_val(10'h106), 2, 5);
        req(4, 0, 10'h000, 8'h00, 0, 4);
        ioctl_upload = 1'b0;

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/hiscore_upload.md
Name: hiscore_upload

Overview:
- Upload-side responder for the hiscore save path; the counterpart of the restore logic that writes scores into game RAM.
- Captures the hiscore config table streamed on ioctl index 3.
- On each upload byte request from the HPS, maps the linear save-file offset onto the table's scattered game-RAM regions, reads game RAM and returns the byte with an ioctl_wait handshake.
- Sits between hps_io and the game-RAM read port, alongside the existing hiscore block.

Parameters:
- RAM_AW, 10, game-RAM address width; ram_address is truncated to this.
- ENTRY_AW, 4, log2 of maximum table entries (16).
- RAM_LATENCY, 1, cycles from registered ram_address/ram_read to valid ram_data_in (range 1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  HPS download active
- ioctl_upload  in  1  HPS upload active
- ioctl_wr  in  1  download byte strobe
- ioctl_rd  in  1  upload byte request strobe, one cycle
- ioctl_addr  in  25  byte address: download offset or upload offset
- ioctl_dout  in  8  download data
- ioctl_index  in  8  ioctl file index; the config table is index 3
- ioctl_din  out  8  upload data returned to HPS
- ioctl_wait  out  1  high while a request is outstanding
- ram_address  out  RAM_AW  game-RAM read address
- ram_read  out  1  one-cycle read strobe
- ram_data_in  in  8  game-RAM read data
- upload_size  out  16  total save-file bytes (sum of entry lengths)

Behaviour:
- Reset state:
  - Outputs: ioctl_din=0, ioctl_wait=0, ram_address=0, ram_read=0, upload_size=0.
  - Internals: entry_count=0, FSM=IDLE.
- Config capture:
  - Record format: 8-byte records; record n = ioctl_addr[ENTRY_AW+2:3]; byte k = ioctl_addr[2:0].
  - Bytes 1..3 form base[23:0] (byte1 is MSB); byte0 is ignored.
  - Byte4 is length. Bytes 5..7 are ignored here.
  - Captured only when ioctl_download & ioctl_wr & ioctl_index==3.
  - Rising edge of ioctl_download with index 3 clears entry_count and upload_size.
  - On the byte4 write: entry_count <= n+1 and upload_size <= upload_size + length (16-bit).
  - Records are assumed to arrive in ascending order.
  - Addresses beyond 2^ENTRY_AW records are ignored.
- FSM states: IDLE, SEEK, ISSUE, WAIT, DONE.
  - Cursor registers: cur_entry and cur_start (file offset of cur_entry's first byte).
- IDLE:
  - ioctl_rd & ioctl_upload latches off = ioctl_addr[15:0], sets ioctl_wait=1 and moves to SEEK.
  - If off < cur_start, first reset cur_entry=0 and cur_start=0 (backward seek).
  - ioctl_rd while not uploading is ignored.
- SEEK, one entry per cycle:
  - cur_entry >= entry_count → ioctl_din <= 0x00, go to DONE. No RAM access (out-of-range offset).
  - off < cur_start+length[cur_entry] → go to ISSUE.
  - Otherwise cur_start += length, cur_entry++, stay in SEEK. This also skips zero-length entries.
- ISSUE:
  - ram_address <= (base + off - cur_start)[RAM_AW-1:0] and ram_read <= 1 for exactly one cycle.
  - Load the latency counter, go to WAIT.
- WAIT:
  - After RAM_LATENCY cycles, ioctl_din <= ram_data_in and go to DONE.
- DONE: ioctl_wait <= 0, go to IDLE.
- Latency, for a request with rd sampled at T and no entry step:
  - ioctl_wait high from T+1.
  - ram_read high at T+2.
  - ioctl_din valid and ioctl_wait low at T+4+RAM_LATENCY.
  - Each extra SEEK step adds 1 cycle.
- Boundary conditions:
  - ioctl_rd while ioctl_wait=1 is ignored; no queueing.
  - ioctl_upload falling in any non-IDLE state aborts to IDLE next cycle: ioctl_wait=0, ram_read=0, ioctl_din unchanged.
  - reset mid-operation behaves the same as the abort and also clears the table count.
  - Config download during an upload is not supported; table writes still occur.
  - Cursor is retained between requests, so sequential reads cost no extra seek cycles.
  - upload_size saturates at 0xFFFF.

Test Plan:
- Config with record0 {00 00 00 0B, 0F} and record1 {00 00 00 23, 04}: upload_size=19, entry_count=2.
- RAM_LATENCY=1, rd addr 0: ram_read pulse with ram_address=0x00B at T+2; ioctl_din=RAM[0x00B] with wait low at T+5.
- Sequential rd addr 14 then 15 → ram_address 0x019, then 0x023 (one extra SEEK cycle). Then addr 18 → 0x026.
- rd addr 19 and addr 300: no ram_read, ioctl_din=0x00, wait low after SEEK/DONE.
- rd addr 16 then addr 2: backward seek → ram_address 0x00D, correct data.
- Deassert ioctl_upload during WAIT → ioctl_wait=0 next cycle, no capture.
- Assert reset mid-SEEK → all outputs at reset values, upload_size=0.
- Re-download with one record of length 4 → upload_size=4.
